// File: rtl/mdu_sequencer.sv
// Multi-cycle RV32M multiply/divide sequencer for the execute stage.
// Multiplies take two cycles; divides use a 32-step restoring divider.
module mdu_sequencer (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  func3_q, func3_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] result_q, result_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        start_signed;
  logic [31:0] abs_a, abs_b;
  logic        mul_a_sext, mul_b_sext;
  logic [63:0] mul_a, mul_b, product;
  logic [32:0] trial;
  logic [31:0] quo_fix, rem_fix;
  logic        select_unused;

  // func7[5] is always zero for M ops and carries no information here.
  assign select_unused = SELECT[0];

  assign start_signed = ~SELECT[2];
  assign abs_a = (start_signed && DATA1[31]) ? -DATA1 : DATA1;
  assign abs_b = (start_signed && DATA2[31]) ? -DATA2 : DATA2;

  assign mul_a_sext = (func3_q == 3'b001) || (func3_q == 3'b010);
  assign mul_b_sext = (func3_q == 3'b001);
  assign mul_a      = {{32{mul_a_sext & op_a_q[31]}}, op_a_q};
  assign mul_b      = {{32{mul_b_sext & op_b_q[31]}}, op_b_q};
  assign product    = mul_a * mul_b;

  // During DIV, op_a holds the shifting quotient and op_b the divisor magnitude.
  assign trial   = {1'b0, rem_q[31:0], op_a_q[31]} - {2'b00, op_b_q};
  assign quo_fix = neg_quo_q ? -op_a_q : op_a_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_comb begin
    state_d   = state_q;
    func3_d   = func3_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          func3_d   = SELECT[4:2];
          op_a_d    = DATA1;
          op_b_d    = DATA2;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = start_signed & (DATA1[31] ^ DATA2[31]);
          neg_rem_d = start_signed & DATA1[31];
          if (!SELECT[1]) begin
            result_d = '0;
            state_d  = S_DONE;
          end else if (!SELECT[4]) begin
            state_d = S_MUL;
          end else if (DATA2 == 32'h0) begin
            result_d = SELECT[3] ? DATA1 : 32'hFFFF_FFFF;
            state_d  = S_DONE;
          end else if (start_signed && DATA1 == 32'h8000_0000 &&
                       DATA2 == 32'hFFFF_FFFF) begin
            result_d = SELECT[3] ? 32'h0 : 32'h8000_0000;
            state_d  = S_DONE;
          end else begin
            op_a_d  = abs_a;
            op_b_d  = abs_b;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = (func3_q == 3'b000) ? product[31:0] : product[63:32];
        state_d  = S_DONE;
      end
      S_DIV: begin
        if (!trial[32]) begin
          rem_d  = trial[31:0];
          op_a_d = {op_a_q[30:0], 1'b1};
        end else begin
          rem_d  = {rem_q[30:0], op_a_q[31]};
          op_a_d = {op_a_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = func3_q[1] ? rem_fix : quo_fix;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A squash wins over everything, including a same-cycle START.
    if (FLUSH) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_DONE);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= S_IDLE;
      func3_q   <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      func3_q   <= func3_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: directed RV32M cases, abort/reset
// scenarios and randomized operations checked against an arithmetic model.
module tb_mdu_sequencer;

  logic        CLK     = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START   = 1'b0;
  logic        FLUSH   = 1'b0;
  logic [4:0]  SELECT  = '0;
  logic [31:0] DATA1   = '0;
  logic [31:0] DATA2   = '0;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int          testCount  = 0;
  int          failCount  = 0;
  logic [31:0] lastResult = '0;

  localparam logic [4:0] OP_MUL    = 5'b000_10;
  localparam logic [4:0] OP_MULH   = 5'b001_10;
  localparam logic [4:0] OP_MULHSU = 5'b010_10;
  localparam logic [4:0] OP_MULHU  = 5'b011_10;
  localparam logic [4:0] OP_DIV    = 5'b100_10;
  localparam logic [4:0] OP_DIVU   = 5'b101_10;
  localparam logic [4:0] OP_REM    = 5'b110_10;
  localparam logic [4:0] OP_REMU   = 5'b111_10;

  always #5 CLK = ~CLK;

  mdu_sequencer dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .START   (START),
    .SELECT  (SELECT),
    .DATA1   (DATA1),
    .DATA2   (DATA2),
    .FLUSH   (FLUSH),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .RESULT  (RESULT)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] refResult(input logic [4:0] sel,
                                                   input logic [31:0] a,
                                                   input logic [31:0] b);
    longint      sp;
    logic [63:0] up;
    int          sa;
    int          sb;
    sa = $signed(a);
    sb = $signed(b);
    if (!sel[1]) return 32'h0;
    case (sel[4:2])
      3'd0: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      3'd1: begin sp = longint'(sa) * longint'(sb); up = sp; return up[63:32]; end
      3'd2: begin sp = longint'(sa) * longint'({32'h0, b}); up = sp; return up[63:32]; end
      3'd3: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [4:0] sel, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!sel[1]) return 1;
    if (!sel[4]) return 2;
    if (b == 0) return 1;
    if (!sel[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic applyStimulus(input logic [4:0] sel, input logic [31:0] a,
                               input logic [31:0] b);
    @(negedge CLK);
    START  = 1'b1;
    SELECT = sel;
    DATA1  = a;
    DATA2  = b;
  endtask

  // START stays asserted until DONE, so any premature re-acceptance shows up.
  task automatic checkOutput(input string tag, input logic [4:0] sel,
                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expRes;
    int          expLat;
    int          cycles;
    logic        stable;
    expRes = refResult(sel, a, b);
    expLat = refLatency(sel, a, b);
    stable = 1'b1;
    @(posedge CLK);
    #1;
    cycles = 1;
    while (!DONE && cycles < 60) begin
      if (!BUSY || RESULT !== lastResult) stable = 1'b0;
      @(posedge CLK);
      #1;
      cycles++;
    end
    check({tag, " done"}, 32'(DONE), 32'd1);
    check({tag, " latency"}, 32'(cycles), 32'(expLat));
    check({tag, " result"}, RESULT, expRes);
    check({tag, " busy/hold"}, 32'({stable, BUSY}), 32'd3);
    START      = 1'b0;
    lastResult = expRes;
    @(posedge CLK);
    #1;
    check({tag, " idle"}, 32'({BUSY, DONE}), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [4:0] sel, input logic [31:0] a,
                       input logic [31:0] b);
    applyStimulus(sel, a, b);
    checkOutput(tag, sel, a, b);
  endtask

  initial begin
    logic        sawDone;
    logic [4:0]  rsel;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (3) @(posedge CLK);
    #1;
    check("reset outputs", {BUSY, DONE, RESULT[29:0]}, 32'h0);
    check("reset result", RESULT, 32'h0);
    @(negedge CLK);
    RESET_N = 1'b1;

    runOp("MULH -2*3", OP_MULH, 32'hFFFF_FFFE, 32'd3);
    runOp("MULHU -2*3", OP_MULHU, 32'hFFFF_FFFE, 32'd3);
    runOp("MULHSU -1*-1", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("MUL -1*-1", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("DIV -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
    runOp("REM -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2);
    runOp("DIVU 100/7", OP_DIVU, 32'd100, 32'd7);
    runOp("REMU 100/7", OP_REMU, 32'd100, 32'd7);
    runOp("DIVU 5/0", OP_DIVU, 32'd5, 32'd0);
    runOp("REM 5/0", OP_REM, 32'd5, 32'd0);
    runOp("DIV ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("REM ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("illegal", 5'b101_00, 32'd9, 32'd3);
    runOp("DIVU 100/7 again", OP_DIVU, 32'd100, 32'd7);

    // Flush in cycle 10 of a divide while START is still held.
    sawDone = 1'b0;
    applyStimulus(OP_DIV, 32'd1000, 32'd3);
    @(posedge CLK);
    #1;
    repeat (9) begin
      if (DONE) sawDone = 1'b1;
      @(posedge CLK);
      #1;
    end
    @(negedge CLK);
    FLUSH = 1'b1;
    @(posedge CLK);
    #1;
    check("flush busy", 32'(BUSY), 32'd0);
    check("flush result", RESULT, lastResult);
    @(negedge CLK);
    FLUSH = 1'b0;
    START = 1'b0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (DONE || BUSY) sawDone = 1'b1;
    end
    check("flush no done", 32'(sawDone), 32'd0);
    check("flush result kept", RESULT, lastResult);

    // Asynchronous reset in the middle of a divide, between clock edges.
    applyStimulus(OP_DIV, 32'd12345, 32'd7);
    @(posedge CLK);
    repeat (5) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    check("async reset busy/done", 32'({BUSY, DONE}), 32'd0);
    check("async reset result", RESULT, 32'h0);
    START      = 1'b0;
    lastResult = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    runOp("MUL after reset", OP_MUL, 32'd1234, 32'd5678);

    for (int i = 0; i < 24; i++) begin
      rsel = {3'($urandom_range(0, 7)), 2'b10};
      if ($urandom_range(0, 7) == 0) rsel[1] = 1'b0;
      ra = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      runOp($sformatf("rand%0d sel=%b", i, rsel), rsel, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
